// File: rtl/riscv_mem_pkg.sv
// Shared types for the memory-stage LSU: funct3 encodings, FSM states, latched request.
// Pure declarations; no timing or flow control of its own.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RESP,
    DONE,
    DRAIN
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lsu_size_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [1:0]  lane;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } lsu_req_t;

  // Undefined encodings (011, 110, 111) all land on the word size.
  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store be/wdata and lane choice, load lane extract + extension.
// Zero latency, no flow control; MISALIGN_TRAP_EN adds the misalignment flag output.
module lsu_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [1:0]  st_lane,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
`ifdef MISALIGN_TRAP_EN
  output logic        st_misaligned,
`endif
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  lsu_size_t st_size;
  lsu_size_t ld_size;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign st_size = f3_size(st_funct3);
  assign ld_size = f3_size(ld_funct3);

  // Lane is forced aligned for the access size, so an untrapped misaligned
  // access simply drops its low address bits.
  always_comb begin
    st_lane  = 2'b00;
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_size)
      SZ_B: begin
        st_lane  = st_addr_lo;
        st_be    = 4'b0001 << st_addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_H: begin
        st_lane  = {st_addr_lo[1], 1'b0};
        st_be    = 4'b0011 << {st_addr_lo[1], 1'b0};
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign st_misaligned = ((st_size == SZ_H) && st_addr_lo[0]) ||
                         ((st_size == SZ_W) && (st_addr_lo != 2'b00));
`endif

  assign ld_byte = ld_rdata[{ld_lane, 3'b000} +: 8];
  assign ld_half = ld_rdata[{ld_lane[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = ld_rdata;
    case (ld_size)
      SZ_B:    ld_data = {{24{~ld_funct3[2] & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data = {{16{~ld_funct3[2] & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit; store stalls >=2 cycles, load >=3, timeout after TIMEOUT_CYCLES.
// Holds the pipeline via stall_out until gnt/rvalid; MISALIGN_TRAP_EN traps misaligned accesses.
module mem_stage_lsu
  import riscv_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] ALU_res_in,
  input  logic [31:0] data_write_in,
  input  logic        flush,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_data_out,
  output logic        stall_out,
  output logic        misalign_out,
  output logic        fault_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t       state;
  logic [CNT_W-1:0] cnt;
  lsu_req_t         req_q;

  logic        access;
  logic        trap;
  logic        start;
  logic [1:0]  st_lane;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
`ifdef MISALIGN_TRAP_EN
  logic        st_misaligned;
`endif

  lsu_align u_align (
    .st_funct3     (funct3_in),
    .st_addr_lo    (ALU_res_in[1:0]),
    .st_data       (data_write_in),
    .st_lane       (st_lane),
    .st_be         (st_be),
    .st_wdata      (st_wdata),
`ifdef MISALIGN_TRAP_EN
    .st_misaligned (st_misaligned),
`endif
    .ld_funct3     (req_q.funct3),
    .ld_lane       (req_q.lane),
    .ld_rdata      (dmem_rdata),
    .ld_data       (ld_data)
  );

  assign access = in_valid & (mem_read_in | mem_write_in) & ~flush;

`ifdef MISALIGN_TRAP_EN
  assign trap = st_misaligned;
`else
  assign trap = 1'b0;
`endif

  assign start        = (state == IDLE) & access & ~trap;
  assign misalign_out = (state == IDLE) & access & trap;
  assign stall_out    = start | (state == REQ) | (state == WAIT_RESP) | (state == DRAIN);

  assign dmem_we    = req_q.we;
  assign dmem_addr  = req_q.addr;
  assign dmem_be    = req_q.be;
  assign dmem_wdata = req_q.wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      req_q        <= '0;
      dmem_req     <= 1'b0;
      mem_data_out <= '0;
      fault_out    <= 1'b0;
    end else begin
      fault_out <= 1'b0;
      case (state)
        IDLE: begin
          mem_data_out <= '0;
          if (start) begin
            req_q.we     <= mem_write_in & ~mem_read_in;
            req_q.funct3 <= funct3_in;
            req_q.lane   <= st_lane;
            req_q.addr   <= {ALU_res_in[31:2], 2'b00};
            req_q.be     <= st_be;
            req_q.wdata  <= st_wdata;
            dmem_req     <= 1'b1;
            state        <= REQ;
          end
        end
        REQ: begin
          // A grant coinciding with flush still issued the access on the bus.
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (req_q.we) begin
              state <= flush ? IDLE : DONE;
            end else begin
              cnt   <= '0;
              state <= flush ? DRAIN : WAIT_RESP;
            end
          end else if (flush) begin
            dmem_req <= 1'b0;
            state    <= IDLE;
          end
        end
        WAIT_RESP: begin
          cnt <= cnt + 1'b1;
          if (flush) begin
            state <= dmem_rvalid ? IDLE : DRAIN;
          end else if (dmem_rvalid) begin
            mem_data_out <= ld_data;
            state        <= DONE;
          end else if (cnt == CNT_LAST) begin
            fault_out    <= 1'b1;
            mem_data_out <= '0;
            state        <= DONE;
          end
        end
        DONE: begin
          mem_data_out <= '0;
          state        <= IDLE;
        end
        DRAIN: begin
          if (dmem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
